// File: rtl/rf_pkg.sv
// Shared defaults and index/data types for the integer register file.
package rf_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_idx_t;
  typedef logic [XLEN_DEF-1:0] xword_t;
endpackage

// File: rtl/reg_file_sb_if.sv
// Read, write, issue and scoreboard bundle between the core and the register file.
interface reg_file_sb_if
  import rf_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   RA;
  logic [NRD*XLEN-1:0] RD;
  logic [NRD-1:0]      RBusy;
  logic [NWR-1:0]      WE;
  logic [NWR*AW-1:0]   WA;
  logic [NWR*XLEN-1:0] WD;
  logic [NWR-1:0]      WClr;
  logic                IssueV;
  logic [AW-1:0]       IssueRd;
  logic [NREGS-1:0]    BusyVec;
  logic [AW:0]         BusyCnt;

  modport master (
    output RA, WE, WA, WD, WClr, IssueV, IssueRd,
    input  RD, RBusy, BusyVec, BusyCnt
  );

  modport slave (
    input  RA, WE, WA, WD, WClr, IssueV, IssueRd,
    output RD, RBusy, BusyVec, BusyCnt
  );
endinterface

// File: rtl/rf_wr_arb.sv
// Per-address write-port select: highest-index enabled port targeting addr_i wins.
module rf_wr_arb #(
  parameter int XLEN = 32,
  parameter int NWR  = 2,
  parameter int AW   = 5
) (
  input  logic [NWR-1:0]      we_i,
  input  logic [NWR*AW-1:0]   wa_i,
  input  logic [NWR*XLEN-1:0] wd_i,
  input  logic [NWR-1:0]      wclr_i,
  input  logic [AW-1:0]       addr_i,
  output logic [XLEN-1:0]     data_o,
  output logic                hit_o,
  output logic                clr_o
);
  // Address 0 never matches, which keeps x0 unwritable and never released.
  always_comb begin
    data_o = '0;
    hit_o  = 1'b0;
    clr_o  = 1'b0;
    for (int w = 0; w < NWR; w++) begin
      if (we_i[w] && (wa_i[w*AW +: AW] == addr_i) && (addr_i != '0)) begin
        hit_o  = 1'b1;
        data_o = wd_i[w*XLEN +: XLEN];
        if (wclr_i[w]) clr_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/reg_file_sb.sv
// Multi-port integer register file with same-cycle write bypass and busy scoreboard.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 2
) (
  input logic          clk,
  input logic          rst,
  reg_file_sb_if.slave rf
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_q;

  function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < NREGS; i++) c = c + {{AW{1'b0}}, v[i]};
    return c;
  endfunction

  // Next-state per register: write data and scoreboard (issue beats completion).
  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign regs_d[r] = '0;
      assign busy_d[r] = 1'b0;
    end else begin : g_nz
      logic [XLEN-1:0] w_data;
      logic            w_hit, w_clr, set;
      rf_wr_arb #(.XLEN(XLEN), .NWR(NWR), .AW(AW)) u_arb (
        .we_i(rf.WE), .wa_i(rf.WA), .wd_i(rf.WD), .wclr_i(rf.WClr),
        .addr_i(AW'(r)), .data_o(w_data), .hit_o(w_hit), .clr_o(w_clr)
      );
      assign set       = rf.IssueV && (rf.IssueRd == AW'(r));
      assign regs_d[r] = w_hit ? w_data : regs_q[r];
      assign busy_d[r] = set ? 1'b1 : (w_clr ? 1'b0 : busy_q[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      cnt_q  <= popcount(busy_d);
    end
  end

  // Read ports: bypass the winning same-cycle write; a completing write releases the hazard.
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] b_data;
    logic            b_hit, b_clr;
    assign ra = rf.RA[p*AW +: AW];
    rf_wr_arb #(.XLEN(XLEN), .NWR(NWR), .AW(AW)) u_byp (
      .we_i(rf.WE), .wa_i(rf.WA), .wd_i(rf.WD), .wclr_i(rf.WClr),
      .addr_i(ra), .data_o(b_data), .hit_o(b_hit), .clr_o(b_clr)
    );
    assign rf.RD[p*XLEN +: XLEN] = b_hit ? b_data : regs_q[ra];
    assign rf.RBusy[p]           = busy_q[ra] && !b_clr;
  end

  assign rf.BusyVec = busy_q;
  assign rf.BusyCnt = cnt_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: reset, x0, bypass, priority, scoreboard, mid-run reset.
module tb_reg_file_sb;
  import rf_pkg::*;

  localparam int XLEN = 32, NREGS = 32, NRD = 2, NWR = 2, AW = 5;

  logic clk = 1'b0;
  logic rst;
  int   vecs = 0;
  int   errs = 0;

  reg_file_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();
  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst(rst), .rf(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running exp finished");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    bus.RA = '0; bus.WE = '0; bus.WA = '0; bus.WD = '0; bus.WClr = '0;
    bus.IssueV = 1'b0; bus.IssueRd = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [AW-1:0] a;
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    vecs++; if (bus.BusyVec !== '0) begin errs++; $display("FAIL rst_busyvec: got %h exp 0", bus.BusyVec); end
    vecs++; if (bus.BusyCnt !== '0) begin errs++; $display("FAIL rst_busycnt: got %0d exp 0", bus.BusyCnt); end
    for (int i = 0; i < NREGS; i++) begin
      a = AW'(i);
      bus.RA = {a, a};
      #1;
      vecs++; if (bus.RD !== '0) begin errs++; $display("FAIL rst_rd r%0d: got %h exp 0", i, bus.RD); end
      vecs++; if (bus.RBusy !== 2'b00) begin errs++; $display("FAIL rst_rbusy r%0d: got %b exp 00", i, bus.RBusy); end
    end
    // Writes to x0 are discarded, both bypassed and stored.
    idle();
    bus.WE = 2'b01; bus.WA[0 +: AW] = 5'd0; bus.WD[0 +: XLEN] = 32'hDEADBEEF;
    #1;
    vecs++; if (bus.RD[0 +: XLEN] !== 32'h0) begin errs++; $display("FAIL x0_bypass: got %h exp 0", bus.RD[0 +: XLEN]); end
    tick();
    idle();
    #1;
    vecs++; if (bus.RD[0 +: XLEN] !== 32'h0) begin errs++; $display("FAIL x0_stored: got %h exp 0", bus.RD[0 +: XLEN]); end
  endtask

  task automatic test_write_bypass();
    idle();
    bus.WE = 2'b01; bus.WA[0 +: AW] = 5'd5; bus.WD[0 +: XLEN] = 32'h12345678;
    bus.RA = {5'd5, 5'd5};
    #1;
    vecs++; if (bus.RD[0 +: XLEN] !== 32'h12345678) begin errs++; $display("FAIL byp_rd0: got %h exp 12345678", bus.RD[0 +: XLEN]); end
    vecs++; if (bus.RD[XLEN +: XLEN] !== 32'h12345678) begin errs++; $display("FAIL byp_rd1: got %h exp 12345678", bus.RD[XLEN +: XLEN]); end
    tick();
    bus.WE = '0;
    #1;
    vecs++; if (bus.RD[0 +: XLEN] !== 32'h12345678) begin errs++; $display("FAIL wr_stored: got %h exp 12345678", bus.RD[0 +: XLEN]); end
  endtask

  task automatic test_priority();
    idle();
    bus.WE = 2'b11;
    bus.WA = {5'd7, 5'd7};
    bus.WD = {32'h5555FFFF, 32'hAAAA0000};
    bus.RA = {5'd5, 5'd7};
    #1;
    vecs++; if (bus.RD[0 +: XLEN] !== 32'h5555FFFF) begin errs++; $display("FAIL prio_byp: got %h exp 5555ffff", bus.RD[0 +: XLEN]); end
    vecs++; if (bus.RD[XLEN +: XLEN] !== 32'h12345678) begin errs++; $display("FAIL prio_other: got %h exp 12345678", bus.RD[XLEN +: XLEN]); end
    tick();
    bus.WE = '0;
    #1;
    vecs++; if (bus.RD[0 +: XLEN] !== 32'h5555FFFF) begin errs++; $display("FAIL prio_stored: got %h exp 5555ffff", bus.RD[0 +: XLEN]); end
  endtask

  task automatic test_scoreboard();
    idle();
    bus.IssueV = 1'b1; bus.IssueRd = 5'd3; bus.RA = {5'd0, 5'd3};
    #1;
    vecs++; if (bus.RBusy[0] !== 1'b0) begin errs++; $display("FAIL sb_issue_same: got %b exp 0", bus.RBusy[0]); end
    tick();
    idle();
    bus.RA = {5'd0, 5'd3};
    #1;
    vecs++; if (bus.BusyVec !== 32'h0000_0008) begin errs++; $display("FAIL sb_vec_set: got %h exp 00000008", bus.BusyVec); end
    vecs++; if (bus.BusyCnt !== 6'd1) begin errs++; $display("FAIL sb_cnt_set: got %0d exp 1", bus.BusyCnt); end
    vecs++; if (bus.RBusy !== 2'b01) begin errs++; $display("FAIL sb_rbusy: got %b exp 01", bus.RBusy); end
    // Clear request without a write enable must be ignored.
    bus.WClr = 2'b01; bus.WA[0 +: AW] = 5'd3;
    #1;
    vecs++; if (bus.RBusy[0] !== 1'b1) begin errs++; $display("FAIL sb_clr_no_we_comb: got %b exp 1", bus.RBusy[0]); end
    tick();
    vecs++; if (bus.BusyVec !== 32'h0000_0008) begin errs++; $display("FAIL sb_clr_no_we_reg: got %h exp 00000008", bus.BusyVec); end
    bus.WE = 2'b01; bus.WClr = 2'b01; bus.WA[0 +: AW] = 5'd3; bus.WD[0 +: XLEN] = 32'h42;
    #1;
    vecs++; if (bus.RBusy[0] !== 1'b0) begin errs++; $display("FAIL sb_wb_rbusy: got %b exp 0", bus.RBusy[0]); end
    vecs++; if (bus.RD[0 +: XLEN] !== 32'h42) begin errs++; $display("FAIL sb_wb_rd: got %h exp 42", bus.RD[0 +: XLEN]); end
    tick();
    idle();
    #1;
    vecs++; if (bus.BusyVec !== '0) begin errs++; $display("FAIL sb_vec_clr: got %h exp 0", bus.BusyVec); end
    vecs++; if (bus.BusyCnt !== 6'd0) begin errs++; $display("FAIL sb_cnt_clr: got %0d exp 0", bus.BusyCnt); end
  endtask

  task automatic test_collision();
    idle();
    bus.IssueV = 1'b1; bus.IssueRd = 5'd9;
    tick();
    idle();
    bus.IssueV = 1'b1; bus.IssueRd = 5'd9;
    bus.WE = 2'b10; bus.WClr = 2'b10; bus.WA[AW +: AW] = 5'd9; bus.WD[XLEN +: XLEN] = 32'h0000_0999;
    bus.RA = {5'd9, 5'd0};
    #1;
    vecs++; if (bus.RBusy !== 2'b00) begin errs++; $display("FAIL col_rbusy_same: got %b exp 00", bus.RBusy); end
    tick();
    idle();
    bus.RA = {5'd9, 5'd0};
    #1;
    vecs++; if (bus.BusyVec !== 32'h0000_0200) begin errs++; $display("FAIL col_vec: got %h exp 00000200", bus.BusyVec); end
    vecs++; if (bus.BusyCnt !== 6'd1) begin errs++; $display("FAIL col_cnt: got %0d exp 1", bus.BusyCnt); end
    vecs++; if (bus.RD[XLEN +: XLEN] !== 32'h0000_0999) begin errs++; $display("FAIL col_data: got %h exp 00000999", bus.RD[XLEN +: XLEN]); end
    vecs++; if (bus.RBusy !== 2'b10) begin errs++; $display("FAIL col_rbusy_next: got %b exp 10", bus.RBusy); end
    bus.IssueV = 1'b1; bus.IssueRd = 5'd0;
    tick();
    bus.IssueV = 1'b0;
    #1;
    vecs++; if (bus.BusyVec !== 32'h0000_0200) begin errs++; $display("FAIL x0_issue_vec: got %h exp 00000200", bus.BusyVec); end
    vecs++; if (bus.RBusy[0] !== 1'b0) begin errs++; $display("FAIL x0_rbusy: got %b exp 0", bus.RBusy[0]); end
  endtask

  task automatic test_mid_reset();
    idle();
    bus.IssueV = 1'b1; bus.IssueRd = 5'd1;
    bus.WE = 2'b11; bus.WA = {5'd2, 5'd1}; bus.WD = {32'h2222, 32'h1111};
    tick();
    bus.IssueRd = 5'd2; bus.WE = 2'b01; bus.WA[0 +: AW] = 5'd4; bus.WD[0 +: XLEN] = 32'h4444;
    tick();
    bus.IssueRd = 5'd4; bus.WE = '0;
    tick();
    idle();
    #1;
    vecs++; if (bus.BusyCnt !== 6'd4) begin errs++; $display("FAIL pre_rst_cnt: got %0d exp 4", bus.BusyCnt); end
    vecs++; if (bus.BusyVec !== 32'h0000_0216) begin errs++; $display("FAIL pre_rst_vec: got %h exp 00000216", bus.BusyVec); end
    rst = 1'b1;
    bus.WE = 2'b01; bus.WA[0 +: AW] = 5'd6; bus.WD[0 +: XLEN] = 32'h6666;
    bus.IssueV = 1'b1; bus.IssueRd = 5'd8;
    tick();
    rst = 1'b0;
    idle();
    #1;
    vecs++; if (bus.BusyVec !== '0) begin errs++; $display("FAIL mrst_vec: got %h exp 0", bus.BusyVec); end
    vecs++; if (bus.BusyCnt !== 6'd0) begin errs++; $display("FAIL mrst_cnt: got %0d exp 0", bus.BusyCnt); end
    for (int i = 1; i <= 8; i++) begin
      bus.RA = {AW'(i), AW'(i)};
      #1;
      vecs++; if (bus.RD !== '0) begin errs++; $display("FAIL mrst_rd r%0d: got %h exp 0", i, bus.RD); end
    end
  endtask

  initial begin
    rst = 1'b0;
    idle();
    @(negedge clk);
    test_reset();
    test_write_bypass();
    test_priority();
    test_scoreboard();
    test_collision();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
